// File: rtl/instr_fetch_unit_if.sv
// Bundles the fetch unit's memory request/response, redirect and decode-side handshake signals.
// master = fetch unit, slave = memory/datapath environment.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc, if_pc_plus4,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc, if_pc_plus4,
        output if_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps up to DEPTH requests in flight and buffers
// returned instructions (tagged with their PC) in a circular buffer for decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_fetch_unit_if.master     bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_slot_pc    [DEPTH];
    logic [31:0]      r_slot_instr [DEPTH];
    logic [DEPTH-1:0] r_slot_filled;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_fill;
    logic [CNT_W-1:0] r_alloc_cnt;
    logic [CNT_W-1:0] r_pend_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [CNT_W:0]   w_credits;
    logic             w_req_valid;
    logic             w_fire;
    logic             w_rsp_drop;
    logic             w_rsp_fill;
    logic             w_pop;
    logic [CNT_W-1:0] w_drop_redirect;
    logic [31:0]      w_redirect_tgt;

    // Credits cover both live slots and stale requests whose responses are still owed.
    assign w_credits   = {1'b0, r_alloc_cnt} + {1'b0, r_drop_cnt};
    assign w_req_valid = rst_n && (w_credits < (CNT_W+1)'(DEPTH));
    assign w_fire      = w_req_valid && bus.imem_req_ready;
    assign w_rsp_drop  = bus.imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_fill  = bus.imem_rsp_valid && (r_drop_cnt == '0) && (r_pend_cnt != '0);
    assign w_pop       = r_slot_filled[r_head] && bus.if_ready;

    // Everything still owed by memory at the redirect edge becomes stale, including a same-cycle fire.
    assign w_drop_redirect = r_drop_cnt + r_pend_cnt + CNT_W'(w_fire)
                           - CNT_W'(w_rsp_drop | w_rsp_fill);
    assign w_redirect_tgt  = bus.redirect_pc & ~32'd3;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.if_valid       = r_slot_filled[r_head];
    assign bus.if_instr       = r_slot_instr[r_head];
    assign bus.if_pc          = r_slot_pc[r_head];
    assign bus.if_pc_plus4    = r_slot_pc[r_head] + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_slot_filled <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_fill        <= '0;
            r_alloc_cnt   <= '0;
            r_pend_cnt    <= '0;
            r_drop_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot_pc[i]    <= '0;
                r_slot_instr[i] <= '0;
            end
        end else begin
            r_alloc_cnt <= r_alloc_cnt + CNT_W'(w_fire) - CNT_W'(w_pop);
            r_pend_cnt  <= r_pend_cnt + CNT_W'(w_fire) - CNT_W'(w_rsp_fill);
            r_drop_cnt  <= r_drop_cnt - CNT_W'(w_rsp_drop);
            if (w_fire) begin
                r_slot_pc[r_tail] <= r_fetch_pc;
                r_tail            <= r_tail + PTR_W'(1);
                r_fetch_pc        <= r_fetch_pc + 32'd4;
            end
            // In-order responses always land in the oldest unfilled slot.
            if (w_rsp_fill) begin
                r_slot_instr[r_fill]  <= bus.imem_rsp_data;
                r_slot_filled[r_fill] <= 1'b1;
                r_fill                <= r_fill + PTR_W'(1);
            end
            if (w_pop) begin
                r_slot_filled[r_head] <= 1'b0;
                r_head                <= r_head + PTR_W'(1);
            end
            if (bus.redirect_valid) begin
                r_slot_filled <= '0;
                r_head        <= '0;
                r_tail        <= '0;
                r_fill        <= '0;
                r_alloc_cnt   <= '0;
                r_pend_cnt    <= '0;
                r_drop_cnt    <= w_drop_redirect;
                r_fetch_pc    <= w_redirect_tgt;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: variable-latency in-order memory model plus a
// stream-level reference (expected fetch address, expected delivered PC, credit accounting).
module tb_instr_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        memq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          epoch;
    int          ret_cnt;
    int          last_due;
    int          lat_min = 1;
    int          lat_max = 1;
    int          pops;
    int          fires;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    logic [31:0] first_pop_pc;
    logic [31:0] key;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ key;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        epoch     = 0;
        ret_cnt   = 0;
        last_due  = -1;
        exp_fetch = RESET_PC;
        exp_pc    = RESET_PC;
    endtask

    task automatic drive_idle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        chk({tag, "_req_addr"},  bus.imem_req_addr, RESET_PC);
        chk({tag, "_if_valid"},  32'(bus.if_valid), 32'd0);
        chk({tag, "_if_instr"},  bus.if_instr, 32'd0);
        chk({tag, "_if_pc"},     bus.if_pc, 32'd0);
        chk({tag, "_if_pc4"},    bus.if_pc_plus4, 32'd4);
    endtask

    // One clock cycle: drive at negedge, sample/check 1ns later, advance the reference model.
    task automatic cycle(input bit rdy, input bit ifr, input bit redir, input logic [31:0] tgt);
        bit   rsp;
        bit   fire;
        bit   pop;
        int   due;
        req_t r;
        @(negedge clk);
        rsp = (memq.size() > 0) && (memq[0].due <= cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(memq[0].addr) : $urandom;
        bus.imem_req_ready = rdy;
        bus.if_ready       = ifr;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        #1;
        chk("req_valid", 32'(bus.imem_req_valid), 32'((memq.size() + ret_cnt) < DEPTH));
        if (bus.imem_req_valid && !redir)
            chk("req_addr", bus.imem_req_addr, exp_fetch);
        chk("if_valid", 32'(bus.if_valid), 32'(ret_cnt > 0));
        if (ret_cnt > 0) begin
            chk("if_pc",    bus.if_pc, exp_pc);
            chk("if_instr", bus.if_instr, mem_word(exp_pc));
            chk("if_pc4",   bus.if_pc_plus4, exp_pc + 32'd4);
        end
        fire = bus.imem_req_valid && rdy;
        pop  = (ret_cnt > 0) && ifr;
        if (pop) begin
            if (pops == 0) first_pop_pc = exp_pc;
            pops++;
            exp_pc = exp_pc + 32'd4;
            ret_cnt--;
        end
        if (rsp) begin
            r = memq.pop_front();
            if (r.epoch == epoch) ret_cnt++;
        end
        if (fire) begin
            fires++;
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: exp_fetch, epoch: epoch, due: due});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redir) begin
            epoch++;
            ret_cnt   = 0;
            exp_fetch = {tgt[31:2], 2'b00};
            exp_pc    = exp_fetch;
        end
        cyc++;
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        key = $urandom;
        drive_idle();
        model_reset();
        #3;
        check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming at full rate with single-cycle memory.
        lat_min = 1; lat_max = 1; pops = 0;
        repeat (30) cycle(1'b1, 1'b1, 1'b0, '0);
        chk("p1_throughput", pops, 32'd28);

        // Decode stalled: exactly DEPTH requests, head held, then drain in order.
        async_reset("rst1");
        fires = 0;
        repeat (10) cycle(1'b1, 1'b0, 1'b0, '0);
        chk("p2_fires", fires, DEPTH);
        chk("p2_hold_pc", bus.if_pc, 32'h0);
        repeat (10) cycle(1'b1, 1'b1, 1'b0, '0);

        // Random memory back-pressure and decode stalls.
        lat_min = 1; lat_max = 3;
        repeat (200) cycle(1'($urandom_range(1, 0)), $urandom_range(9, 0) < 7, 1'b0, '0);

        // Redirect to an unaligned target with three slow requests in flight.
        async_reset("rst2");
        lat_min = 4; lat_max = 4;
        repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        pops = 0;
        repeat (14) cycle(1'b1, 1'b1, 1'b0, '0);
        chk("p4_first_pc", first_pop_pc, 32'h0000_0100);

        // Redirect coinciding with a fire and a response, then random redirect traffic.
        lat_min = 2; lat_max = 2;
        repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_2000);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);
        lat_min = 1; lat_max = 4;
        repeat (300) cycle(1'($urandom_range(1, 0)), $urandom_range(9, 0) < 6,
                           $urandom_range(99, 0) < 8, $urandom);

        // Address wrap at the top of the space, then an asynchronous reset mid-stream.
        lat_min = 1; lat_max = 1;
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (8) cycle(1'b1, 1'b1, 1'b0, '0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, '0);
        async_reset("rst3");
        repeat (8) cycle(1'b1, 1'b1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the single-cycle MIPS datapath and its control unit.
- Owns the architectural fetch PC and issues word requests to instruction memory over a valid/ready request channel with variable-latency, in-order responses.
- Buffers returned instructions, each tagged with its PC, in a small reservation buffer.
- Presents instructions to decode through a valid/ready handshake and accepts branch/jump redirects from the datapath, discarding stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4: buffer slots and maximum memory requests in flight. Power of 2, at least 2; DEPTH >= 3 is required for 1 instr/cycle.

Ports:
- clk in 1: rising-edge clock.
- rst_n in 1: reset, asynchronous assert, active-low.
- imem_req_valid out 1: fetch request valid.
- imem_req_ready in 1: memory accepts request.
- imem_req_addr out 32: word-aligned byte address.
- imem_rsp_valid in 1: response valid. In order, always accepted, no back-pressure.
- imem_rsp_data in 32: instruction word.
- redirect_valid in 1: one-cycle pulse; new fetch target.
- redirect_pc in 32: target; bits [1:0] ignored (forced 0).
- if_valid out 1: instruction available to decode.
- if_ready in 1: decode consumes head.
- if_instr out 32: head instruction.
- if_pc out 32: PC of head instruction.
- if_pc_plus4 out 32: if_pc + 4, mod 2^32.

Behaviour:
- Reset (rst_n low, asynchronous):
  - fetch_pc = RESET_PC; all slots empty; alloc_count = 0; drop_count = 0.
  - imem_req_valid = 0, if_valid = 0, imem_req_addr = RESET_PC, if_instr/if_pc = 0, if_pc_plus4 = 4.
- Reset asserted mid-operation abandons all state immediately. The memory must also be reset; responses to pre-reset requests are not tracked.
- Slots form a circular buffer with head/tail pointers, tracked by alloc_count (0..DEPTH).
  - Each slot holds {pc, instr, filled}.
- Request issue:
  - imem_req_valid = rst_n && (alloc_count + drop_count < DEPTH).
  - imem_req_addr = fetch_pc.
- Request fire = imem_req_valid && imem_req_ready. On fire:
  - Allocate tail slot with pc = fetch_pc, filled = 0.
  - fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0).
- While imem_req_valid && !imem_req_ready, imem_req_addr is held stable. The only exception is a redirect.
- Response handling:
  - If drop_count > 0: discard the response and decrement drop_count.
  - Otherwise: write imem_rsp_data into the oldest unfilled slot and set filled = 1.
- imem_rsp_valid with no outstanding request is a protocol violation. It is ignored and the bench flags it.
- Output path:
  - if_valid = head slot filled. No response-to-output bypass.
  - if_instr, if_pc and if_pc_plus4 are driven from the head slot.
  - Outputs are stable while if_valid && !if_ready.
- Pop = if_valid && if_ready: free the head slot and advance head.
  - The freed slot is usable for issue from the next cycle.
  - Pop, fire and response may all occur in one cycle.
  - alloc_count_next = alloc_count + fire - pop.
- Latency: request fires in cycle k; response in cycle k+m (m >= 1); if_valid in cycle k+m+1.
- Redirect (redirect_valid = 1 in cycle N) has highest priority:
  - A pop in cycle N completes normally.
  - At the edge ending cycle N, all slots are cleared: alloc_count = 0, head = tail.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - drop_count_next = drop_count + unfilled_slots + fire_N - rsp_valid_N. Every request older than the redirect is dropped, including one that fires in cycle N with the old address.
  - imem_req_addr may change combinationally in cycle N (permitted exception to the stability rule).
  - if_valid = 0 in cycle N+1.
  - Fetch resumes at the new target as soon as alloc_count + drop_count < DEPTH.
- Back-to-back redirects: the last one wins, and drop accounting accumulates per the drop_count formula.
- Buffer full (alloc_count + drop_count == DEPTH): imem_req_valid = 0 until a pop or a response drop frees a credit.

Test Plan:
1. Reset release, RESET_PC = 0, imem_req_ready = 1, memory returns 1 cycle after fire, if_ready = 1 -> addrs 0x0, 0x4, 0x8 … one per cycle; first if_valid 2 cycles after first fire; if_pc/if_instr pairs match; sustained 1 instr/cycle with DEPTH = 4.
2. if_ready = 0 for 10 cycles -> exactly DEPTH requests issued, then imem_req_valid = 0; if_pc = 0x0 held stable. Raising if_ready drains 0x0, 0x4, 0x8, 0xC in order, then fetch resumes at 0x10.
3. imem_req_ready toggling 0/1 randomly -> imem_req_addr stable while stalled; no address skipped or duplicated.
4. Redirect to 0x0000_0103 with 3 requests in flight (responses 4 cycles latent) -> next addr 0x100; the 3 stale responses are discarded; first delivered if_pc = 0x100 with its correct instruction.
5. Redirect in the same cycle as a request fire and a response -> drop_count follows the formula; no stale instruction ever reaches if_valid.
6. fetch_pc = 0xFFFF_FFF8 -> next requests 0xFFFF_FFFC then 0x0; if_pc_plus4 = 0x0 for PC 0xFFFF_FFFC. rst_n pulsed low mid-stream -> outputs return to reset values asynchronously.
